// File: rtl/cmsdk_reset_sequencer.sv
// cmsdk_reset_sequencer
//   Reset controller between the free-running clock / power-on source and the
//   Cortex-M0 subsystem. Merges button, SYSRESETREQ, watchdog and lockup
//   requests. Holds the system in reset for a fixed stretch, then releases
//   PORESETn, HRESETn and PRESETn in a staggered order. Keeps a sticky
//   reset-cause vector that software can read and clear.
//
// Ports
//   CLK          in   single clock, rising edge
//   RST          in   synchronous active-high power-on reset
//   EXTRST_REQ   in   push-button request (async, synchronised + debounced here)
//   SYSRESETREQ  in   core system reset request (level)
//   WDOGRESREQ   in   watchdog reset request (level)
//   LOCKUP       in   core lockup indication (level)
//   LOCKUPRESET  in   1 = LOCKUP causes a reset, 0 = LOCKUP ignored
//   CAUSE_CLR    in   one-cycle pulse clearing RSTCAUSE
//   PORESETn     out  power-on/debug reset, active-low
//   HRESETn      out  AHB/core reset, active-low
//   PRESETn      out  APB peripheral reset, active-low
//   RSTCAUSE     out  sticky causes [0]POR [1]EXT [2]SYSRESETREQ [3]WDOG [4]LOCKUP
//   SEQ_BUSY     out  high until the sequence reaches the run state
module cmsdk_reset_sequencer #(
  parameter int unsigned POR_CYCLES = 16,
  parameter int unsigned SYS_CYCLES = 8,
  parameter int unsigned STAGGER    = 2,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EXTRST_REQ,
  input  logic       SYSRESETREQ,
  input  logic       WDOGRESREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUPRESET,
  input  logic       CAUSE_CLR,
  output logic       PORESETn,
  output logic       HRESETn,
  output logic       PRESETn,
  output logic [4:0] RSTCAUSE,
  output logic       SEQ_BUSY
);

  localparam int unsigned CNT_MAX =
    (POR_CYCLES > SYS_CYCLES) ? ((POR_CYCLES > STAGGER) ? POR_CYCLES : STAGGER)
                              : ((SYS_CYCLES > STAGGER) ? SYS_CYCLES : STAGGER);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LAST = CW'(SYS_CYCLES - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    S_POR  = 2'd0,
    S_SYS  = 2'd1,
    S_PERI = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ext_s1_q, ext_s2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          ext_deb;

  logic [4:0]    cause_q, cause_d;
  logic          poresetn_q, poresetn_d;
  logic          hresetn_q, hresetn_d;
  logic          presetn_q, presetn_d;
  logic          busy_q, busy_d;

  logic [4:0]    src;
  logic          req;
  logic          capture;

  // Debounce counter saturates at DEB_CYCLES; reaching it means the
  // synchronised button has been high for that many consecutive samples.
  always_comb begin
    deb_d = '0;
    if (ext_s2_q) begin
      deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
    end
  end

  assign ext_deb = (deb_q == DEB_MAX);

  assign src     = {LOCKUP & LOCKUPRESET, WDOGRESREQ, SYSRESETREQ, ext_deb, 1'b0};
  assign req     = |src;
  assign capture = req && (state_q != S_POR);

  // Set wins over clear for sources active on the same edge.
  assign cause_d = (CAUSE_CLR ? 5'b00000 : cause_q) | (capture ? src : 5'b00000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      S_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = S_SYS;
          cnt_d   = '0;
        end
      end
      S_SYS: begin
        if (cnt_q == SYS_LAST) begin
          state_d = S_PERI;
          cnt_d   = '0;
        end
      end
      S_PERI: begin
        if (req) begin
          state_d = S_SYS;
          cnt_d   = '0;
        end else if (cnt_q == STG_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (req) begin
          state_d = S_SYS;
        end
      end
      default: begin
        state_d = S_POR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each edge appears on the
  // clock that enters the corresponding state.
  always_comb begin
    poresetn_d = (state_d != S_POR);
    hresetn_d  = (state_d == S_PERI) || (state_d == S_RUN);
    presetn_d  = (state_d == S_RUN);
    busy_d     = (state_d != S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_POR;
      cnt_q      <= '0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      deb_q      <= '0;
      cause_q    <= 5'b00001;
      poresetn_q <= 1'b0;
      hresetn_q  <= 1'b0;
      presetn_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_s1_q   <= EXTRST_REQ;
      ext_s2_q   <= ext_s1_q;
      deb_q      <= deb_d;
      cause_q    <= cause_d;
      poresetn_q <= poresetn_d;
      hresetn_q  <= hresetn_d;
      presetn_q  <= presetn_d;
      busy_q     <= busy_d;
    end
  end

  assign PORESETn = poresetn_q;
  assign HRESETn  = hresetn_q;
  assign PRESETn  = presetn_q;
  assign RSTCAUSE = cause_q;
  assign SEQ_BUSY = busy_q;

endmodule

// File: tb/tb_cmsdk_reset_sequencer.sv
// Testbench for cmsdk_reset_sequencer: timeline-based reference model
// (outputs derived from edges elapsed since the last sequence start) compared
// every cycle, plus literal timing checks for the directed scenarios.
module tb_cmsdk_reset_sequencer;

  localparam int POR = 16;
  localparam int SYS = 8;
  localparam int STG = 2;
  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EXTRST_REQ = 1'b0;
  logic       SYSRESETREQ = 1'b0;
  logic       WDOGRESREQ = 1'b0;
  logic       LOCKUP = 1'b0;
  logic       LOCKUPRESET = 1'b0;
  logic       CAUSE_CLR = 1'b0;
  logic       PORESETn, HRESETn, PRESETn, SEQ_BUSY;
  logic [4:0] RSTCAUSE;

  cmsdk_reset_sequencer #(
    .POR_CYCLES(POR),
    .SYS_CYCLES(SYS),
    .STAGGER(STG),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EXTRST_REQ(EXTRST_REQ),
    .SYSRESETREQ(SYSRESETREQ),
    .WDOGRESREQ(WDOGRESREQ),
    .LOCKUP(LOCKUP),
    .LOCKUPRESET(LOCKUPRESET),
    .CAUSE_CLR(CAUSE_CLR),
    .PORESETn(PORESETn),
    .HRESETn(HRESETn),
    .PRESETn(PRESETn),
    .RSTCAUSE(RSTCAUSE),
    .SEQ_BUSY(SEQ_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge CLK);
  endtask

  // ---------------- reference model ----------------
  // n        : edges since the last RST edge
  // sys_start: edge on which the current system reset began
  bit         m_valid = 1'b0;
  int         n = 0;
  int         sys_start = 0;
  bit         hist[$];
  bit   [4:0] m_cause = 5'b00001;
  bit         e_por, e_h, e_p, e_busy;

  function automatic bit ext_debounced();
    // Synchroniser delays the raw button by two samples; debounce then
    // needs DEB consecutive highs.
    for (int i = 2; i <= DEB + 1; i++) begin
      int idx;
      idx = hist.size() - 1 - i;
      if (idx < 0) return 1'b0;
      if (!hist[idx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_valid   = 1'b1;
      n         = 0;
      sys_start = 0;
      hist.delete();
      m_cause   = 5'b00001;
    end else begin
      bit [4:0] src;
      bit       req, prev_por;
      n++;
      src      = {LOCKUP & LOCKUPRESET, WDOGRESREQ, SYSRESETREQ, ext_debounced(), 1'b0};
      req      = |src;
      prev_por = (n - 1) < POR;
      hist.push_back(EXTRST_REQ);
      if (hist.size() > 16) void'(hist.pop_front());
      // Stretch phase ignores requests; once it is over any request restarts it.
      if (!prev_por && req && ((n - 1) - sys_start) >= SYS) sys_start = n;
      m_cause = (CAUSE_CLR ? 5'b00000 : m_cause) | ((!prev_por && req) ? src : 5'b00000);
      if (n == POR) sys_start = n;
    end
    e_por  = (n >= POR);
    e_h    = e_por && ((n - sys_start) >= SYS);
    e_p    = e_por && ((n - sys_start) >= SYS + STG);
    e_busy = !e_p;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_poresetn", {4'b0, PORESETn}, {4'b0, e_por});
      chk("model_hresetn",  {4'b0, HRESETn},  {4'b0, e_h});
      chk("model_presetn",  {4'b0, PRESETn},  {4'b0, e_p});
      chk("model_busy",     {4'b0, SEQ_BUSY}, {4'b0, e_busy});
      chk("model_cause",    RSTCAUSE,         m_cause);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ext_left;
    int rst_left;

    // T1: power-on sequence
    step(3);
    chk("rst_poresetn", {4'b0, PORESETn}, 5'd0);
    chk("rst_busy", {4'b0, SEQ_BUSY}, 5'd1);
    chk("rst_cause", RSTCAUSE, 5'b00001);
    RST = 1'b0;
    step(15);
    chk("t1_por_low_e15", {4'b0, PORESETn}, 5'd0);
    step(1);
    chk("t1_por_high_e16", {4'b0, PORESETn}, 5'd1);
    step(7);
    chk("t1_h_low_e23", {4'b0, HRESETn}, 5'd0);
    step(1);
    chk("t1_h_high_e24", {4'b0, HRESETn}, 5'd1);
    step(1);
    chk("t1_p_low_e25", {4'b0, PRESETn}, 5'd0);
    chk("t1_busy_e25", {4'b0, SEQ_BUSY}, 5'd1);
    step(1);
    chk("t1_p_high_e26", {4'b0, PRESETn}, 5'd1);
    chk("t1_busy_e26", {4'b0, SEQ_BUSY}, 5'd0);
    chk("t1_cause", RSTCAUSE, 5'b00001);
    step(2);

    // T2: one-cycle SYSRESETREQ in run
    SYSRESETREQ = 1'b1;
    step(1);
    SYSRESETREQ = 1'b0;
    chk("t2_h_low", {4'b0, HRESETn}, 5'd0);
    chk("t2_p_low", {4'b0, PRESETn}, 5'd0);
    chk("t2_por_high", {4'b0, PORESETn}, 5'd1);
    step(7);
    chk("t2_h_low_8th", {4'b0, HRESETn}, 5'd0);
    step(1);
    chk("t2_h_rise", {4'b0, HRESETn}, 5'd1);
    step(1);
    chk("t2_p_stagger", {4'b0, PRESETn}, 5'd0);
    step(1);
    chk("t2_p_rise", {4'b0, PRESETn}, 5'd1);
    chk("t2_cause", RSTCAUSE, 5'b00101);
    step(2);

    // T3: button glitch, then a held press
    EXTRST_REQ = 1'b1;
    step(3);
    EXTRST_REQ = 1'b0;
    step(8);
    chk("t3_glitch_no_reset", {4'b0, HRESETn}, 5'd1);
    EXTRST_REQ = 1'b1;
    step(1);
    step(5);
    chk("t3_not_yet", {4'b0, HRESETn}, 5'd1);
    step(1);
    chk("t3_reset_start", {4'b0, HRESETn}, 5'd0);
    step(3);
    EXTRST_REQ = 1'b0;
    step(14);
    chk("t3_cause_ext", {4'b0, RSTCAUSE[1]}, 5'd1);
    chk("t3_back_run", {4'b0, PRESETn}, 5'd1);

    // T4: lockup gated by LOCKUPRESET, then with watchdog
    LOCKUP = 1'b1;
    step(4);
    chk("t4_lockup_ignored", {4'b0, HRESETn}, 5'd1);
    LOCKUPRESET = 1'b1;
    WDOGRESREQ  = 1'b1;
    step(1);
    LOCKUP = 1'b0;
    WDOGRESREQ = 1'b0;
    chk("t4_lockup_reset", {4'b0, HRESETn}, 5'd0);
    chk("t4_cause_bits", {3'b0, RSTCAUSE[4:3]}, 5'b00011);
    step(12);

    // T5: watchdog during peripheral stagger restarts system reset
    SYSRESETREQ = 1'b1;
    step(1);
    SYSRESETREQ = 1'b0;
    step(8);
    chk("t5_in_peri_h", {4'b0, HRESETn}, 5'd1);
    chk("t5_in_peri_p", {4'b0, PRESETn}, 5'd0);
    WDOGRESREQ = 1'b1;
    step(1);
    WDOGRESREQ = 1'b0;
    chk("t5_restart", {4'b0, HRESETn}, 5'd0);
    step(7);
    chk("t5_full_hold", {4'b0, HRESETn}, 5'd0);
    step(1);
    chk("t5_release", {4'b0, HRESETn}, 5'd1);
    step(4);

    // T6: cause clear, clear with set, RST mid-sequence
    CAUSE_CLR = 1'b1;
    step(1);
    CAUSE_CLR = 1'b0;
    chk("t6_clear", RSTCAUSE, 5'b00000);
    CAUSE_CLR = 1'b1;
    SYSRESETREQ = 1'b1;
    step(1);
    CAUSE_CLR = 1'b0;
    SYSRESETREQ = 1'b0;
    chk("t6_clear_set", RSTCAUSE, 5'b00100);
    step(3);
    RST = 1'b1;
    step(1);
    chk("t6_rst_por", {4'b0, PORESETn}, 5'd0);
    chk("t6_rst_h", {4'b0, HRESETn}, 5'd0);
    chk("t6_rst_p", {4'b0, PRESETn}, 5'd0);
    chk("t6_rst_cause", RSTCAUSE, 5'b00001);
    RST = 1'b0;
    step(30);

    // Stuck watchdog: repeated sequences
    WDOGRESREQ = 1'b1;
    step(40);
    WDOGRESREQ = 1'b0;
    step(15);

    // Randomised traffic
    ext_left = 0;
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 99) < 2) ext_left = $urandom_range(1, 10);
      EXTRST_REQ = (ext_left > 0);
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 999) < 3) rst_left = $urandom_range(1, 2);
      RST         = (rst_left > 0);
      SYSRESETREQ = ($urandom_range(0, 99) < 2);
      WDOGRESREQ  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) LOCKUP = ~LOCKUP;
      if ($urandom_range(0, 99) < 2) LOCKUPRESET = ~LOCKUPRESET;
      CAUSE_CLR   = ($urandom_range(0, 99) < 4);
      step(1);
    end
    RST = 1'b0;
    EXTRST_REQ = 1'b0;
    SYSRESETREQ = 1'b0;
    WDOGRESREQ = 1'b0;
    LOCKUP = 1'b0;
    CAUSE_CLR = 1'b0;
    step(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
